fetch_mem_arbiter: RTL and testbench

- Sequences the single-ported instruction/data memory between two requesters.
  - The fetch stage (IF) issues instruction reads.
  - The data-memory stage (DM) issues loads and stores.
- Grants one access per cycle. DM has priority, but a starvation counter forces a fetch grant after a bounded streak of DM grants.
- Read data is registered and returned one cycle after the grant. The grant output drives the fetch stage's PC enable, so a denied fetch stalls the PC.

---
 rtl/fetch_mem_arbiter_if.sv | 54 +++++
 rtl/fetch_mem_arbiter.sv | 113 +++++++++++
 tb/tb_fetch_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_mem_arbiter_if.sv
// Bus bundle between the fetch stage, the data-memory stage, the single-ported
// memory and the arbiter that sequences them.
//
// Handshake: a requester raises req with addr/we/wdata and holds all of them
// stable until it samples its gnt high at a rising edge. Each gnt consumes
// exactly one access. Keeping req high after a gnt starts the next access
// (streaming). The response (rvalid plus rdata for reads, rvalid alone as a
// store ack) appears in the cycle right after the granting edge.
interface fetch_mem_arbiter_if;
  // fetch stage
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [7:0]  if_rdata_high;
  logic [7:0]  if_rdata_low;
  // data-memory stage
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [7:0]  dm_wdata_high;
  logic [7:0]  dm_wdata_low;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [7:0]  dm_rdata_high;
  logic [7:0]  dm_rdata_low;
  // memory
  logic [15:0] mem_address;
  logic        mem_we;
  logic [7:0]  mem_data_write_high;
  logic [7:0]  mem_data_write_low;
  logic [7:0]  mem_data_read_high;
  logic [7:0]  mem_data_read_low;

  // arbiter side
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata_high, if_rdata_low,
    input  dm_req, dm_we, dm_addr, dm_wdata_high, dm_wdata_low,
    output dm_gnt, dm_rvalid, dm_rdata_high, dm_rdata_low,
    output mem_address, mem_we, mem_data_write_high, mem_data_write_low,
    input  mem_data_read_high, mem_data_read_low
  );

  // requesters and memory side
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata_high, if_rdata_low,
    output dm_req, dm_we, dm_addr, dm_wdata_high, dm_wdata_low,
    input  dm_gnt, dm_rvalid, dm_rdata_high, dm_rdata_low,
    input  mem_address, mem_we, mem_data_write_high, mem_data_write_low,
    output mem_data_read_high, mem_data_read_low
  );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Single-ported instruction/data memory arbiter. The data stage has priority,
// but after STARVE_LIMIT consecutive data grants with a fetch waiting, the fetch
// is forced through. Read data is registered and returned one cycle after the
// grant. if_gnt doubles as the PC enable, so a denied fetch stalls the PC.
module fetch_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3  // 0..15; 0 gives fetch absolute priority
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_mem_arbiter_if.slave   bus,
  output logic [1:0]           dbg_state,
  output logic [3:0]           dbg_streak
);

  // Response FSM: the state names the owner of the previous cycle's access.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IF_RD = 2'd1;
  localparam logic [1:0] DM_RD = 2'd2;
  localparam logic [1:0] DM_WR = 2'd3;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic [1:0] state_next;
  logic [3:0] streak;
  logic [3:0] streak_next;
  logic       force_if;
  logic       if_gnt;
  logic       dm_gnt;

  // Grant decision: data wins unless the fetch has waited out its streak.
  // if_gnt is derived from dm_gnt, so the two can never be high together.
  always_comb begin
    force_if = bus.if_req && (streak == LIMIT);
    dm_gnt   = bus.dm_req && !force_if;
    if_gnt   = bus.if_req && !dm_gnt;
  end

  assign bus.if_gnt = if_gnt;
  assign bus.dm_gnt = dm_gnt;

  // Memory port mux: the data stage drives everything when granted; otherwise
  // the PC is presented as a read address with write data parked at zero.
  always_comb begin
    bus.mem_address         = bus.if_addr;
    bus.mem_we              = 1'b0;
    bus.mem_data_write_high = 8'h00;
    bus.mem_data_write_low  = 8'h00;
    if (dm_gnt) begin
      bus.mem_address         = bus.dm_addr;
      bus.mem_we              = bus.dm_we;
      bus.mem_data_write_high = bus.dm_wdata_high;
      bus.mem_data_write_low  = bus.dm_wdata_low;
    end
  end

  // Next response state follows this cycle's grant.
  always_comb begin
    state_next = IDLE;
    if (if_gnt) begin
      state_next = IF_RD;
    end else if (dm_gnt) begin
      state_next = bus.dm_we ? DM_WR : DM_RD;
    end
  end

  // Starvation streak: counts data grants that overtook a waiting fetch,
  // saturating at the limit; any fetch grant or idle fetch clears it.
  always_comb begin
    streak_next = 4'd0;
    if (dm_gnt && bus.if_req) begin
      streak_next = (streak >= LIMIT) ? LIMIT : streak + 4'd1;
    end
  end

  // State and streak registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      streak <= 4'd0;
    end else begin
      state  <= state_next;
      streak <= streak_next;
    end
  end

  // Read data capture into the granted requester's registers; stores leave the
  // data-stage registers untouched, and unselected registers hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.if_rdata_high <= 8'h00;
      bus.if_rdata_low  <= 8'h00;
      bus.dm_rdata_high <= 8'h00;
      bus.dm_rdata_low  <= 8'h00;
    end else begin
      if (if_gnt) begin
        bus.if_rdata_high <= bus.mem_data_read_high;
        bus.if_rdata_low  <= bus.mem_data_read_low;
      end
      if (dm_gnt && !bus.dm_we) begin
        bus.dm_rdata_high <= bus.mem_data_read_high;
        bus.dm_rdata_low  <= bus.mem_data_read_low;
      end
    end
  end

  assign bus.if_rvalid = (state == IF_RD);
  assign bus.dm_rvalid = (state == DM_RD) || (state == DM_WR);

  assign dbg_state  = state;
  assign dbg_streak = streak;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Testbench for fetch_mem_arbiter: directed scenarios plus randomized traffic,
// all checked against a behavioural model of memory contents, grant priority
// and one-cycle response latency.
module tb_fetch_mem_arbiter;

  localparam int LIMIT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_mem_arbiter_if bus ();
  fetch_mem_arbiter_if bus0 ();

  logic [1:0] st;
  logic [3:0] sk;
  logic [1:0] st0;
  logic [3:0] sk0;

  fetch_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(st), .dbg_streak(sk)
  );

  fetch_mem_arbiter #(.STARVE_LIMIT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .dbg_state(st0), .dbg_streak(sk0)
  );

  // ---------------- memories ----------------
  // bench-side memory the DUT actually talks to
  logic [15:0] bmem [0:32767];
  assign bus.mem_data_read_high = bmem[bus.mem_address[15:1]][15:8];
  assign bus.mem_data_read_low  = bmem[bus.mem_address[15:1]][7:0];
  always @(posedge clk) begin
    if (bus.mem_we) bmem[bus.mem_address[15:1]] <= {bus.mem_data_write_high, bus.mem_data_write_low};
  end
  assign bus0.mem_data_read_high = 8'h11;
  assign bus0.mem_data_read_low  = 8'h22;

  // ---------------- reference model / scoreboard ----------------
  logic [15:0] exp_mem [0:32767];
  logic [17:0] exp_q[$];       // {kind, data}: 0 none, 1 fetch, 2 load, 3 store
  logic [15:0] exp_if_data;
  logic [15:0] exp_dm_data;
  int          wins;           // data grants in a row that overtook a waiting fetch
  logic        last_if_gnt;
  logic        last_dm_gnt;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_if_data = 16'h0;
    exp_dm_data = 16'h0;
    wins        = 0;
    last_if_gnt = 1'b0;
    last_dm_gnt = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_if(input logic req, input logic [15:0] addr);
    bus.if_req  = req;
    bus.if_addr = addr;
  endtask

  task automatic set_dm(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
    bus.dm_req        = req;
    bus.dm_we         = we;
    bus.dm_addr       = addr;
    bus.dm_wdata_high = wd[15:8];
    bus.dm_wdata_low  = wd[7:0];
  endtask

  // Called right after inputs are driven on the falling edge: checks the
  // response for last cycle's grant, this cycle's grant and memory port,
  // then advances the model past the coming rising edge.
  task automatic check_cycle();
    logic [17:0] e;
    logic [1:0]  kind;
    logic        g_dm;
    logic        g_if;
    #1;
    kind = 2'd0;
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      kind = e[17:16];
      if (kind == 2'd1) exp_if_data = e[15:0];
      if (kind == 2'd2) exp_dm_data = e[15:0];
    end
    check("if_rvalid", bus.if_rvalid, kind == 2'd1);
    check("dm_rvalid", bus.dm_rvalid, (kind == 2'd2) || (kind == 2'd3));
    check("if_rdata", {bus.if_rdata_high, bus.if_rdata_low}, exp_if_data);
    check("dm_rdata", {bus.dm_rdata_high, bus.dm_rdata_low}, exp_dm_data);

    g_dm = bus.dm_req && !(bus.if_req && wins >= LIMIT);
    g_if = bus.if_req && !g_dm;
    check("if_gnt", bus.if_gnt, g_if);
    check("dm_gnt", bus.dm_gnt, g_dm);
    check("streak", sk, wins);
    check("mem_address", bus.mem_address, g_dm ? bus.dm_addr : bus.if_addr);
    check("mem_we", bus.mem_we, g_dm && bus.dm_we);
    check("mem_wdata", {bus.mem_data_write_high, bus.mem_data_write_low},
          g_dm ? {bus.dm_wdata_high, bus.dm_wdata_low} : 16'h0);

    if (g_if) begin
      exp_q.push_back({2'd1, exp_mem[bus.if_addr[15:1]]});
    end else if (g_dm && !bus.dm_we) begin
      exp_q.push_back({2'd2, exp_mem[bus.dm_addr[15:1]]});
    end else if (g_dm) begin
      exp_q.push_back({2'd3, 16'h0});
      exp_mem[bus.dm_addr[15:1]] = {bus.dm_wdata_high, bus.dm_wdata_low};
    end else begin
      exp_q.push_back(18'h0);
    end
    if (g_dm && bus.if_req) wins = (wins + 1 > LIMIT) ? LIMIT : wins + 1;
    else wins = 0;
    last_if_gnt = g_if;
    last_dm_gnt = g_dm;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    set_if(1'b0, 16'h0);
    set_dm(1'b0, 1'b0, 16'h0, 16'h0);
    check_cycle();
  endtask

  int exp_if_tab [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int exp_sk_tab [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [15:0] pc;
  logic [15:0] w;

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 32768; i++) begin
      w          = 16'($urandom);
      bmem[i]    = w;
      exp_mem[i] = w;
    end
    reset = 1'b1;
    set_if(1'b0, 16'h0);
    set_dm(1'b0, 1'b0, 16'h0, 16'h0);
    bus0.if_req = 1'b0; bus0.if_addr = 16'h0;
    bus0.dm_req = 1'b0; bus0.dm_we = 1'b0; bus0.dm_addr = 16'h0;
    bus0.dm_wdata_high = 8'h0; bus0.dm_wdata_low = 8'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_if_rvalid", bus.if_rvalid, 1'b0);
    check("reset_dm_rvalid", bus.dm_rvalid, 1'b0);
    check("reset_rdata", {bus.if_rdata_high, bus.if_rdata_low, bus.dm_rdata_high, bus.dm_rdata_low}, 32'h0);
    check("reset_state", st, 2'd0);
    reset = 1'b0;

    // streaming fetch 0x0000, 0x0002, 0x0004
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_if(1'b1, 16'(i * 2));
      check_cycle();
    end
    idle_cycle();
    idle_cycle();

    // fetch and load collide: load wins, fetch retries next cycle
    @(negedge clk);
    set_if(1'b1, 16'h0010);
    set_dm(1'b1, 1'b0, 16'h0100, 16'h0);
    check_cycle();
    check("collide_mem_address", bus.mem_address, 16'h0100);
    @(negedge clk);
    set_dm(1'b0, 1'b0, 16'h0, 16'h0);
    check_cycle();
    idle_cycle();

    // store then load back
    @(negedge clk);
    set_dm(1'b1, 1'b1, 16'h0200, 16'hABCD);
    check_cycle();
    idle_cycle();
    @(negedge clk);
    set_dm(1'b1, 1'b0, 16'h0200, 16'h0);
    check_cycle();
    idle_cycle();
    check("store_readback", {bus.dm_rdata_high, bus.dm_rdata_low}, 16'hABCD);
    idle_cycle();

    // starvation: both held high for 8 cycles
    pc = 16'h0300;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_if(1'b1, pc);
      set_dm(1'b1, 1'b0, 16'h0400, 16'h0);
      check_cycle();
      check("starve_if_gnt", bus.if_gnt, exp_if_tab[i]);
      check("starve_streak", sk, exp_sk_tab[i]);
      if (last_if_gnt) pc = pc + 16'd2;
    end
    idle_cycle();
    idle_cycle();

    // STARVE_LIMIT = 0 instance: fetch has absolute priority
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus0.if_req = 1'b1; bus0.if_addr = 16'(i * 2);
      bus0.dm_req = 1'b1; bus0.dm_addr = 16'h0500;
      #1;
      check("lim0_if_gnt", bus0.if_gnt, 1'b1);
      check("lim0_dm_gnt", bus0.dm_gnt, 1'b0);
    end
    @(negedge clk);
    bus0.if_req = 1'b0;
    #1;
    check("lim0_dm_gnt_after", bus0.dm_gnt, 1'b1);
    check("lim0_if_gnt_after", bus0.if_gnt, 1'b0);
    @(negedge clk);
    bus0.dm_req = 1'b0;

    // asynchronous reset mid-cycle after a fetch grant
    @(negedge clk);
    set_if(1'b1, 16'h0006);
    check_cycle();
    @(posedge clk);
    #1;
    check("pre_reset_if_rvalid", bus.if_rvalid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_if_rvalid", bus.if_rvalid, 1'b0);
    check("async_rdata", {bus.if_rdata_high, bus.if_rdata_low, bus.dm_rdata_high, bus.dm_rdata_low}, 32'h0);
    check("async_state", st, 2'd0);
    model_reset();
    @(negedge clk);
    set_if(1'b0, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    check_cycle();
    idle_cycle();

    // randomized traffic obeying the hold-until-grant rule
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!(bus.if_req && !last_if_gnt)) begin
        set_if(1'($urandom_range(0, 2) != 0), 16'h0400 + 16'($urandom_range(0, 7)) * 16'd2);
      end
      if (!(bus.dm_req && !last_dm_gnt)) begin
        set_dm(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
               16'h0400 + 16'($urandom_range(0, 7)) * 16'd2, 16'($urandom));
      end
      check_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
